// File: rtl/multibyte_add_sequencer.sv
// Byte-serial wide adder controller around an 8-bit ripple adder slice.
// Ports: in_* / op_* accept side, out_* / res_* result side, add_* slice.
// Option: define ADD_SEQ_OVERFLOW_EN to add the res_ovf signed-overflow output.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
`ifdef ADD_SEQ_OVERFLOW_EN
  ,
  output logic                  res_ovf
`endif
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            last;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic            ovf_q, ovf_d;
`endif

  assign last = (cnt_q == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADD_SEQ_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADD_SEQ_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef ADD_SEQ_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{cnt_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d  = add_cout;
`ifdef ADD_SEQ_OVERFLOW_EN
          // carry into the MSB is recovered from the slice's top bit
          ovf_d   = add_cout ^ (add_a[7] ^ add_b[7] ^ add_sum[7]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[7:0];
      add_b   = b_q[7:0];
      add_cin = carry_q;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
`ifdef ADD_SEQ_OVERFLOW_EN
  assign res_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Bench for multibyte_add_sequencer: NBYTES=4 main instance plus an
// NBYTES=1 instance, each wrapped around a behavioural 8-bit slice.
module tb_multibyte_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res_sum;
  logic        res_cout;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic        res_ovf, res_ovf1;
`endif

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [7:0]  op_a1 = '0;
  logic [7:0]  op_b1 = '0;
  logic        op_cin1 = 1'b0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [7:0]  res_sum1;
  logic        res_cout1;
  logic [7:0]  add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
  assign {add_cout1, add_sum1} =
    {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};

  multibyte_add_sequencer #(.NBYTES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sum(res_sum), .res_cout(res_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
`ifdef ADD_SEQ_OVERFLOW_EN
    , .res_ovf(res_ovf)
`endif
  );

  multibyte_add_sequencer #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .res_sum(res_sum1), .res_cout(res_cout1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1)
`ifdef ADD_SEQ_OVERFLOW_EN
    , .res_ovf(res_ovf1)
`endif
  );

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic c);
    exp_t e;
    {e.cout, e.sum} = {1'b0, a} + {1'b0, b} + {32'h0, c};
    e.ovf = (a[31] == b[31]) && (e.sum[31] != a[31]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands for one accept edge, records
  // the expected result.
  task automatic send(logic [31:0] a, logic [31:0] b, logic c);
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b want 1", in_ready);
    end
    op_a = a;
    op_b = b;
    op_cin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(a, b, c));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 7;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    if (res_sum !== 32'h0) begin
      errors++; $display("FAIL rst_res_sum: got %h want 0", res_sum);
    end
    if (res_cout !== 1'b0) begin
      errors++; $display("FAIL rst_res_cout: got %b want 0", res_cout);
    end
    if (add_a !== 8'h0) begin
      errors++; $display("FAIL rst_add_a: got %h want 0", add_a);
    end
    if (add_b !== 8'h0) begin
      errors++; $display("FAIL rst_add_b: got %h want 0", add_b);
    end
    if (add_cin !== 1'b0) begin
      errors++; $display("FAIL rst_add_cin: got %b want 0", add_cin);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_ripple();
    int n;
    exp_t e;
    send(32'hFFFF_FFFF, 32'h0, 1'b1);
    checks++;
    if (add_a !== 8'hFF || add_cin !== 1'b1) begin
      errors++;
      $display("FAIL ripple_slice_in: got a=%h cin=%b want a=ff cin=1",
               add_a, add_cin);
    end
    wait_out(n);
    e = sb.pop_front();
    checks += 3;
    if (n !== 4) begin
      errors++; $display("FAIL ripple_latency: got %0d want 4", n);
    end
    if (res_sum !== e.sum || e.sum !== 32'h0) begin
      errors++; $display("FAIL ripple_sum: got %h want 00000000", res_sum);
    end
    if (res_cout !== 1'b1) begin
      errors++; $display("FAIL ripple_cout: got %b want 1", res_cout);
    end
    checks++;
    if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL done_slice_in: got %h %h %b want 00 00 0",
               add_a, add_b, add_cin);
    end
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ripple_release: got ov=%b ir=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    int n;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_out(n);
      e = sb.pop_front();
      checks += 2;
      if (n !== 4) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d want 4", i, n);
      end
      if (res_sum !== e.sum || res_cout !== e.cout) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h/%b want %h/%b",
                 i, res_sum, res_cout, e.sum, e.cout);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (e.sum !== 32'h0000_0100 || res_sum !== e.sum) begin
      errors++; $display("FAIL bp_sum: got %h want 00000100", res_sum);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op_a = 32'hDEAD_BEEF;
      op_b = 32'h1234_0000;
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid);
      end
      if (res_sum !== 32'h0000_0100 || res_cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h/%b want 00000100/0",
                 i, res_sum, res_cout);
      end
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc = 0;
    int   nacc = 0;
    int   nres = 0;
    int   acc_cyc[2];
    logic acc, hs;
    exp_t e;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    op_a = 32'h0000_0001;
    op_b = 32'h0000_0001;
    op_cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nres < 2 && cyc < 40) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got %h want none", res_sum);
        end else begin
          e = sb.pop_front();
          if (res_sum !== e.sum || res_cout !== e.cout) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b",
                     nres, res_sum, res_cout, e.sum, e.cout);
          end
        end
        nres++;
      end
      tick();
      cyc++;
      if (acc) begin
        sb.push_back(model(op_a, op_b, op_cin));
        if (nacc < 2) acc_cyc[nacc] = cyc;
        nacc++;
        op_a = 32'h8000_0000;
        op_b = 32'h8000_0000;
        if (nacc >= 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks += 2;
    if (nres !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", nres);
    end
    if (acc_cyc[1] - acc_cyc[0] !== 6) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 6", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    exp_t e;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready);
    end
    if (res_sum !== 32'h0) begin
      errors++; $display("FAIL abort_res_sum: got %h want 0", res_sum);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_out(n);
    e = sb.pop_front();
    checks += 2;
    if (n !== 4) begin
      errors++; $display("FAIL rerun_latency: got %0d want 4", n);
    end
    if (res_sum !== 32'h2345_6789 || res_cout !== 1'b0 ||
        res_sum !== e.sum) begin
      errors++;
      $display("FAIL rerun_result: got %h/%b want 23456789/0",
               res_sum, res_cout);
    end
    retire();
  endtask

`ifdef ADD_SEQ_OVERFLOW_EN
  task automatic test_overflow();
    int n;
    exp_t e;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (res_ovf !== 1'b1 || res_cout !== 1'b0 || res_ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf_pos: got ovf=%b cout=%b want 1 0", res_ovf, res_cout);
    end
    retire();
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checks++;
    if (res_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", res_ovf);
    end
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (res_ovf !== 1'b0 || res_cout !== 1'b1 || res_ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf_neg: got ovf=%b cout=%b want 0 1", res_ovf, res_cout);
    end
    retire();
  endtask
`endif

  task automatic test_nbytes1();
    int n = 0;
    op_a1 = 8'hC8;
    op_b1 = 8'h64;
    op_cin1 = 1'b1;
    in_valid1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL nb1_in_ready: got %b want 1", in_ready1);
    end
    tick();
    in_valid1 = 1'b0;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    checks += 2;
    if (n !== 1) begin
      errors++; $display("FAIL nb1_latency: got %0d want 1", n);
    end
    if (res_sum1 !== 8'h2D || res_cout1 !== 1'b1) begin
      errors++;
      $display("FAIL nb1_result: got %h/%b want 2d/1", res_sum1, res_cout1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL nb1_release: got %b want 0", out_valid1);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADD_SEQ_OVERFLOW_EN
    test_overflow();
`endif
    test_nbytes1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
